// File: rtl/datapath_select_unit_pkg.sv
// Shared encodings and widths for the datapath select unit and the control unit.
// The control unit must drive reg_dst, data_sel and alu_src using these values.
package datapath_select_unit_pkg;

    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int LINK_REG = 31;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;
    localparam logic [1:0] REGDST_R0 = 2'b11;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_MEM  = 2'b01;
    localparam logic [1:0] WB_LINK = 2'b10;
    localparam logic [1:0] WB_ZERO = 2'b11;

    localparam logic ALUSRC_REG = 1'b0;
    localparam logic ALUSRC_IMM = 1'b1;

endpackage

// File: rtl/datapath_select_unit_mux4.sv
// Generic 4:1 multiplexer with a 2-bit select.
// Nested ?: keeps an unknown select visible as X in simulation instead of picking a leg.
module datapath_select_unit_mux4 #(
    parameter int W = 32
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    assign y = sel[1] ? (sel[0] ? d3 : d2)
                      : (sel[0] ? d1 : d0);

endmodule

// File: rtl/datapath_select_unit.sv
// MIPS single-cycle datapath selects (write address, write-back data, ALU operand B)
// plus a registered trace of the last committed register-file write.
module datapath_select_unit
    import datapath_select_unit_pkg::*;
#(
    parameter int DW       = datapath_select_unit_pkg::DW,
    parameter int AW       = datapath_select_unit_pkg::AW,
    parameter int LINK_REG = datapath_select_unit_pkg::LINK_REG
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    reg_dst,
    input  logic [AW-1:0] rt,
    input  logic [AW-1:0] rd,
    output logic [AW-1:0] reg_addr,
    input  logic [1:0]    data_sel,
    input  logic [DW-1:0] alu_result,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] pc_plus4,
    output logic [DW-1:0] wb_data,
    input  logic          alu_src,
    input  logic [DW-1:0] grf_b,
    input  logic [DW-1:0] ext_imm,
    output logic [DW-1:0] alu_b,
    input  logic          reg_write,
    output logic          trace_valid,
    output logic [AW-1:0] trace_addr,
    output logic [DW-1:0] trace_data
);

    localparam logic [AW-1:0] LINK_ADDR = AW'(LINK_REG);

    logic          trace_valid_q, trace_valid_d;
    logic [AW-1:0] trace_addr_q,  trace_addr_d;
    logic [DW-1:0] trace_data_q,  trace_data_d;

    datapath_select_unit_mux4 #(.W(AW)) u_addr_mux (
        .sel (reg_dst),
        .d0  (rt),
        .d1  (rd),
        .d2  (LINK_ADDR),
        .d3  ({AW{1'b0}}),
        .y   (reg_addr)
    );

    datapath_select_unit_mux4 #(.W(DW)) u_wb_mux (
        .sel (data_sel),
        .d0  (alu_result),
        .d1  (mem_data),
        .d2  (pc_plus4),
        .d3  ({DW{1'b0}}),
        .y   (wb_data)
    );

    assign alu_b = (alu_src == ALUSRC_IMM) ? ext_imm : grf_b;

    // Address/data hold when no write commits so the last write stays observable.
    always_comb begin
        trace_valid_d = 1'b0;
        trace_addr_d  = trace_addr_q;
        trace_data_d  = trace_data_q;
        if (reg_write) begin
            trace_valid_d = 1'b1;
            trace_addr_d  = reg_addr;
            trace_data_d  = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trace_valid_q <= 1'b0;
            trace_addr_q  <= '0;
            trace_data_q  <= '0;
        end else begin
            trace_valid_q <= trace_valid_d;
            trace_addr_q  <= trace_addr_d;
            trace_data_q  <= trace_data_d;
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_addr  = trace_addr_q;
    assign trace_data  = trace_data_q;

endmodule

// File: tb/tb_datapath_select_unit.sv
// Directed and randomized checks of datapath_select_unit against a table-driven
// reference model of the select rules and the write-back trace.
module tb_datapath_select_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  reg_dst;
    logic [4:0]  rt, rd, reg_addr;
    logic [1:0]  data_sel;
    logic [31:0] alu_result, mem_data, pc_plus4, wb_data;
    logic        alu_src;
    logic [31:0] grf_b, ext_imm, alu_b;
    logic        reg_write;
    logic        trace_valid;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;

    int checks = 0;
    int passes = 0;

    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    datapath_select_unit dut (
        .clk         (clk),
        .reset       (reset),
        .reg_dst     (reg_dst),
        .rt          (rt),
        .rd          (rd),
        .reg_addr    (reg_addr),
        .data_sel    (data_sel),
        .alu_result  (alu_result),
        .mem_data    (mem_data),
        .pc_plus4    (pc_plus4),
        .wb_data     (wb_data),
        .alu_src     (alu_src),
        .grf_b       (grf_b),
        .ext_imm     (ext_imm),
        .alu_b       (alu_b),
        .reg_write   (reg_write),
        .trace_valid (trace_valid),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data)
    );

    function automatic logic [4:0] ref_addr();
        logic [4:0] t [4];
        t[0] = rt; t[1] = rd; t[2] = 5'd31; t[3] = 5'd0;
        return t[reg_dst];
    endfunction

    function automatic logic [31:0] ref_wb();
        logic [31:0] t [4];
        t[0] = alu_result; t[1] = mem_data; t[2] = pc_plus4; t[3] = 32'h0;
        return t[data_sel];
    endfunction

    function automatic logic [31:0] ref_alu_b();
        return alu_src ? ext_imm : grf_b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_comb(input string tag);
        #1;
        chk({tag, "_reg_addr"}, {27'd0, reg_addr}, {27'd0, ref_addr()});
        chk({tag, "_wb_data"},  wb_data,           ref_wb());
        chk({tag, "_alu_b"},    alu_b,             ref_alu_b());
    endtask

    // Advance one clock, updating the model from the inputs present at the edge.
    task automatic clock_and_check(input string tag);
        if (reset) begin
            m_valid = 1'b0; m_addr = '0; m_data = '0;
        end else if (reg_write) begin
            m_valid = 1'b1; m_addr = ref_addr(); m_data = ref_wb();
        end else begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, "_trace_valid"}, {31'd0, trace_valid}, {31'd0, m_valid});
        chk({tag, "_trace_addr"},  {27'd0, trace_addr},  {27'd0, m_addr});
        chk({tag, "_trace_data"},  trace_data,           m_data);
    endtask

    initial begin
        reset = 1'b1; reg_dst = 2'b00; rt = 5'd8; rd = 5'd9;
        data_sel = 2'b00; alu_result = 32'h0000_0010; mem_data = 32'hDEAD_BEEF;
        pc_plus4 = 32'h0000_3004; alu_src = 1'b0; grf_b = 32'hFFFF_FFFE;
        ext_imm = 32'h0000_7FFF; reg_write = 1'b0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;

        clock_and_check("reset0");
        clock_and_check("reset1");
        reset = 1'b0;

        // Destination select with literal expectations.
        for (int i = 0; i < 4; i++) begin
            logic [4:0] exp_a [4];
            exp_a[0] = 5'd8; exp_a[1] = 5'd9; exp_a[2] = 5'd31; exp_a[3] = 5'd0;
            reg_dst = 2'(i);
            #1;
            chk($sformatf("regdst%0d", i), {27'd0, reg_addr}, {27'd0, exp_a[i]});
        end

        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_w [4];
            exp_w[0] = 32'h10; exp_w[1] = 32'hDEADBEEF; exp_w[2] = 32'h3004; exp_w[3] = 32'h0;
            data_sel = 2'(i);
            #1;
            chk($sformatf("datasel%0d", i), wb_data, exp_w[i]);
        end

        alu_src = 1'b0; #1;
        chk("alusrc0", alu_b, 32'hFFFF_FFFE);
        alu_src = 1'b1; #1;
        chk("alusrc1", alu_b, 32'h0000_7FFF);

        // Trace capture, then hold with changed inputs.
        reg_write = 1'b1; reg_dst = 2'b01; rd = 5'd3; data_sel = 2'b01; mem_data = 32'h1234_5678;
        @(posedge clk); #1;
        chk("cap_valid", {31'd0, trace_valid}, 32'd1);
        chk("cap_addr",  {27'd0, trace_addr},  32'd3);
        chk("cap_data",  trace_data,           32'h1234_5678);
        m_valid = 1'b1; m_addr = 5'd3; m_data = 32'h1234_5678;
        reg_write = 1'b0; rd = 5'd17; mem_data = 32'h0BAD_F00D;
        @(posedge clk); #1;
        chk("hold_valid", {31'd0, trace_valid}, 32'd0);
        chk("hold_addr",  {27'd0, trace_addr},  32'd3);
        chk("hold_data",  trace_data,           32'h1234_5678);
        m_valid = 1'b0;

        // Reset wins over reg_write; combinational paths still follow selects.
        reset = 1'b1; reg_write = 1'b1; reg_dst = 2'b10; data_sel = 2'b10;
        #1;
        chk("rst_comb_addr", {27'd0, reg_addr}, 32'd31);
        chk("rst_comb_wb",   wb_data,           32'h3004);
        @(posedge clk); #1;
        chk("rstprio_valid", {31'd0, trace_valid}, 32'd0);
        chk("rstprio_addr",  {27'd0, trace_addr},  32'd0);
        chk("rstprio_data",  trace_data,           32'd0);
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        reset = 1'b0; reg_write = 1'b0;

        // lw-style access.
        alu_src = 1'b1; data_sel = 2'b01; reg_dst = 2'b00; rt = 5'd2;
        ext_imm = 32'd4; mem_data = 32'hA5A5_A5A5; reg_write = 1'b1;
        #1;
        chk("lw_alu_b",    alu_b,             32'd4);
        chk("lw_reg_addr", {27'd0, reg_addr}, 32'd2);
        chk("lw_wb_data",  wb_data,           32'hA5A5_A5A5);
        @(posedge clk); #1;
        chk("lw_tr_valid", {31'd0, trace_valid}, 32'd1);
        chk("lw_tr_addr",  {27'd0, trace_addr},  32'd2);
        chk("lw_tr_data",  trace_data,           32'hA5A5_A5A5);
        m_valid = 1'b1; m_addr = 5'd2; m_data = 32'hA5A5_A5A5;

        // Randomized traffic against the model, with occasional mid-stream reset.
        for (int n = 0; n < 300; n++) begin
            reset      = ($urandom_range(15) == 0);
            reg_write  = $urandom_range(1);
            reg_dst    = 2'($urandom_range(3));
            data_sel   = 2'($urandom_range(3));
            alu_src    = $urandom_range(1);
            rt         = 5'($urandom);
            rd         = 5'($urandom);
            alu_result = $urandom;
            mem_data   = $urandom;
            pc_plus4   = $urandom;
            grf_b      = $urandom;
            ext_imm    = $urandom;
            check_comb($sformatf("rnd%0d", n));
            clock_and_check($sformatf("rnd%0d", n));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/datapath_select_unit.md
Name: datapath_select_unit

Overview:
- Single-cycle MIPS datapath selection block; merges the three datapath multiplexers into one unit.
- Register-write destination select: rt / rd / $31.
- Write-back data select: ALU result / memory read data / link address.
- ALU operand-B select: register data / extended immediate.
- Selection paths are purely combinational and sit between the control unit, register file, ALU and data memory.
- A small registered write-back trace is added for debug and verification.

Parameters:
- DW, 32, datapath width of data inputs and outputs.
- AW, 5, register-address width.
- LINK_REG, 31, register number written for link (jal) writes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- reg_dst  in  2  destination select: 00 rt, 01 rd, 10 LINK_REG, 11 register 0.
- rt  in  AW  instruction field [20:16].
- rd  in  AW  instruction field [15:11].
- reg_addr  out  AW  selected register-file write address.
- data_sel  in  2  write-back select: 00 ALU, 01 memory, 10 pc_plus4, 11 zero.
- alu_result  in  DW  ALU output.
- mem_data  in  DW  data-memory read data.
- pc_plus4  in  DW  link address.
- wb_data  out  DW  selected register-file write data.
- alu_src  in  1  operand-B select: 0 grf_b, 1 ext_imm.
- grf_b  in  DW  register-file read data 2.
- ext_imm  in  DW  sign- or zero-extended immediate.
- alu_b  out  DW  ALU operand B.
- reg_write  in  1  register-file write enable, used for tracing only.
- trace_valid  out  1  a write-back was committed in the previous cycle.
- trace_addr  out  AW  registered reg_addr of the last committed write.
- trace_data  out  DW  registered wb_data of the last committed write.

Behaviour:
- reg_addr, wb_data and alu_b are combinational, with zero latency.
  - They depend only on the current inputs and never on clk or reset.
  - They must be valid during reset.
- reg_addr:
  - reg_dst=00 gives rt.
  - 01 gives rd.
  - 10 gives LINK_REG (5'd31).
  - 11 gives 5'd0; writes to $0 are harmless.
- wb_data:
  - data_sel=00 gives alu_result.
  - 01 gives mem_data.
  - 10 gives pc_plus4.
  - 11 gives 32'h0.
- alu_b: alu_src=0 gives grf_b; alu_src=1 gives ext_imm.
- Muxing is bitwise pass-through with no width conversion, no sign handling and no arithmetic.
- Any X on a select must not be masked into a legal value (use case/?: semantics).
- Trace registers update on the rising edge of clk.
  - If reset=1: trace_valid<=0, trace_addr<=0, trace_data<=0. Reset has priority over reg_write.
  - Else if reg_write=1: trace_valid<=1, trace_addr<=reg_addr, trace_data<=wb_data.
  - Else: trace_valid<=0, and trace_addr/trace_data hold their previous values.
- Reset asserted mid-stream clears the trace on that edge; the combinational outputs are unaffected.
- A reg_write to register 0 is still traced; filtering is the register file's job.

Decomposition:
- Shared package (e.g. datapath_pkg):
  - REGDST_RT=2'b00, REGDST_RD=2'b01, REGDST_RA=2'b10.
  - WB_ALU=2'b00, WB_MEM=2'b01, WB_LINK=2'b10.
  - ALUSRC_REG=1'b0, ALUSRC_IMM=1'b1.
  - Width constants DW and AW.
- The control unit imports the same encodings.
- One generic sub-module is natural: mux4 (parameterised width, 2-bit select, four data inputs). It is instantiated for reg_addr and wb_data.
- The 2:1 operand mux is written inline.

Test Plan:
- Destination select: rt=5'd8, rd=5'd9.
  - reg_dst=00 -> reg_addr=8; 01 -> 9; 10 -> 31; 11 -> 0.
- Write-back select: alu_result=32'h0000_0010, mem_data=32'hDEAD_BEEF, pc_plus4=32'h0000_3004.
  - data_sel 00/01/10/11 -> wb_data 32'h10 / 32'hDEADBEEF / 32'h3004 / 32'h0.
- Operand B: grf_b=32'hFFFF_FFFE, ext_imm=32'h0000_7FFF.
  - alu_src=0 -> alu_b=32'hFFFFFFFE; alu_src=1 -> alu_b=32'h00007FFF. The change is visible without a clock edge.
- Trace capture: reg_write=1, reg_dst=01, rd=5'd3, data_sel=01, mem_data=32'h1234_5678, rising edge.
  - Expect trace_valid=1, trace_addr=3, trace_data=32'h12345678.
  - Next edge with reg_write=0 -> trace_valid=0, addr/data held.
- Reset priority: reset=1 and reg_write=1 on the same edge -> trace_valid=0, trace_addr=0, trace_data=0.
  - Combinational outputs still follow the selects during reset.
- Lw-style sequence: alu_src=1, data_sel=01, reg_dst=00, rt=5'd2, ext_imm=4, mem_data=32'hA5A5_A5A5, reg_write=1.
  - Expect alu_b=4, reg_addr=2, wb_data=32'hA5A5A5A5, and the trace captures (2, 32'hA5A5A5A5).
